snake_update_sequencer: RTL and testbench

Sequences one game step of the snake on every `game_tik`: computes the new head, shifts the body through an external single-port body RAM, detects wall and self collisions, handles fruit eating and growth, and keeps length and score. Sits between the input direction logic and the body RAM that the renderer reads. It replaces the ad-hoc per-tick update with a single owner of all RAM writes.

---
 rtl/snake_update_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_snake_update_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_update_sequencer.sv
// rtl/snake_update_sequencer.sv - one snake step per game_tik: head move, body RAM shift, collisions, growth, score
// Optional macro: SNAKE_WRAP_EN (grid edges wrap instead of ending the game)
module snake_update_sequencer #(
  parameter int SNAKE_LENGTH_BIT = 4,
  parameter int GRID_W           = 80,
  parameter int GRID_H           = 60
) (
  input  logic                        clock_25,
  input  logic                        reset,
  input  logic                        game_tik,
  input  logic                        restart,
  input  logic                        up,
  input  logic                        down,
  input  logic                        left,
  input  logic                        right,
  input  logic [6:0]                  fruit_x,
  input  logic [6:0]                  fruit_y,
  output logic [SNAKE_LENGTH_BIT-1:0] body_addr,
  output logic                        body_we,
  output logic [6:0]                  body_wr_x,
  output logic [6:0]                  body_wr_y,
  input  logic [6:0]                  body_rd_x,
  input  logic [6:0]                  body_rd_y,
  output logic [6:0]                  snake_head_x,
  output logic [6:0]                  snake_head_y,
  output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
  output logic [7:0]                  score,
  output logic                        busy,
  output logic                        update_done,
  output logic                        fruit_eaten,
  output logic                        collision_detected
);

  localparam int                  LW      = SNAKE_LENGTH_BIT;
  localparam logic [LW-1:0]       MAX_LEN = LW'((1 << LW) - 1);
  localparam logic [6:0]          MID_X   = 7'(GRID_W / 2);
  localparam logic [6:0]          MID_Y   = 7'(GRID_H / 2);
  localparam logic [6:0]          LAST_X  = 7'(GRID_W - 1);
  localparam logic [6:0]          LAST_Y  = 7'(GRID_H - 1);
`ifdef SNAKE_WRAP_EN
  localparam bit                  WALL_KILLS = 1'b0;
`else
  localparam bit                  WALL_KILLS = 1'b1;
`endif

  typedef enum logic [2:0] {INIT0, INIT1, IDLE, CALC, RD, WR, HEAD, DEAD} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  state_t        state, state_nxt;
  dir_t          dir, req_dir, step_dir;
  logic          req_valid;
  logic [6:0]    calc_x, calc_y;
  logic [6:0]    new_x, new_y;
  logic          off_grid, wall_hit, eat_now, grow_now, eat_q, self_hit;
  logic [LW-1:0] top, idx;

  // Opposite directions differ only in bit 0, so a reversal request is simply ignored.
  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_RIGHT;
    if (up)         req_dir = DIR_UP;
    else if (down)  req_dir = DIR_DOWN;
    else if (left)  req_dir = DIR_LEFT;
    else if (right) req_dir = DIR_RIGHT;
    else            req_valid = 1'b0;
    step_dir = dir;
    if (req_valid && (req_dir != dir_t'({dir[1], ~dir[0]})))
      step_dir = req_dir;
  end

  always_comb begin
    calc_x   = snake_head_x;
    calc_y   = snake_head_y;
    off_grid = 1'b0;
    case (step_dir)
      DIR_UP: begin
        if (snake_head_y == 7'd0) begin
          off_grid = 1'b1;
          calc_y   = LAST_Y;
        end else begin
          calc_y = snake_head_y - 7'd1;
        end
      end
      DIR_DOWN: begin
        if (snake_head_y == LAST_Y) begin
          off_grid = 1'b1;
          calc_y   = 7'd0;
        end else begin
          calc_y = snake_head_y + 7'd1;
        end
      end
      DIR_LEFT: begin
        if (snake_head_x == 7'd0) begin
          off_grid = 1'b1;
          calc_x   = LAST_X;
        end else begin
          calc_x = snake_head_x - 7'd1;
        end
      end
      default: begin
        if (snake_head_x == LAST_X) begin
          off_grid = 1'b1;
          calc_x   = 7'd0;
        end else begin
          calc_x = snake_head_x + 7'd1;
        end
      end
    endcase
    wall_hit = WALL_KILLS && off_grid;
    eat_now  = (calc_x == fruit_x) && (calc_y == fruit_y);
    grow_now = eat_now && (snake_length < MAX_LEN);
    // Growing keeps the old tail, so the shift starts one slot higher.
    top      = grow_now ? snake_length : snake_length - LW'(1);
  end

  always_comb begin
    state_nxt = state;
    body_addr = '0;
    body_we   = 1'b0;
    body_wr_x = '0;
    body_wr_y = '0;
    self_hit  = (body_rd_x == new_x) && (body_rd_y == new_y);
    case (state)
      INIT0: begin
        body_we   = 1'b1;
        body_wr_x = MID_X;
        body_wr_y = MID_Y;
        state_nxt = INIT1;
      end
      INIT1: begin
        body_addr = LW'(1);
        body_we   = 1'b1;
        body_wr_x = MID_X - 7'd1;
        body_wr_y = MID_Y;
        state_nxt = IDLE;
      end
      IDLE: begin
        if (restart)       state_nxt = INIT0;
        else if (game_tik) state_nxt = CALC;
      end
      CALC: state_nxt = wall_hit ? DEAD : RD;
      RD: begin
        body_addr = idx - LW'(1);
        state_nxt = WR;
      end
      WR: begin
        body_addr = idx;
        body_wr_x = body_rd_x;
        body_wr_y = body_rd_y;
        if (self_hit) begin
          state_nxt = DEAD;
        end else begin
          body_we   = 1'b1;
          state_nxt = (idx > LW'(1)) ? RD : HEAD;
        end
      end
      HEAD: begin
        body_we   = 1'b1;
        body_wr_x = new_x;
        body_wr_y = new_y;
        state_nxt = IDLE;
      end
      DEAD: begin
        if (restart) state_nxt = INIT0;
      end
      default: state_nxt = INIT0;
    endcase
    if (!reset) body_we = 1'b0;
  end

  assign busy = (state != IDLE) && (state != DEAD);

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      state              <= INIT0;
      dir                <= DIR_RIGHT;
      snake_head_x       <= MID_X;
      snake_head_y       <= MID_Y;
      new_x              <= '0;
      new_y              <= '0;
      snake_length       <= '0;
      score              <= '0;
      idx                <= '0;
      eat_q              <= 1'b0;
      update_done        <= 1'b0;
      fruit_eaten        <= 1'b0;
      collision_detected <= 1'b0;
    end else begin
      state              <= state_nxt;
      update_done        <= 1'b0;
      fruit_eaten        <= 1'b0;
      collision_detected <= (state_nxt == DEAD) && (state != DEAD);
      case (state)
        INIT0: begin
          snake_head_x <= MID_X;
          snake_head_y <= MID_Y;
        end
        INIT1: begin
          snake_length <= LW'(2);
          dir          <= DIR_RIGHT;
        end
        IDLE: if (restart) score <= '0;
        CALC: begin
          dir   <= step_dir;
          new_x <= calc_x;
          new_y <= calc_y;
          eat_q <= eat_now;
          idx   <= top;
        end
        WR: if (!self_hit) idx <= idx - LW'(1);
        HEAD: begin
          snake_head_x <= new_x;
          snake_head_y <= new_y;
          if (eat_q) begin
            if (snake_length < MAX_LEN) snake_length <= snake_length + LW'(1);
            if (score != 8'hFF)         score        <= score + 8'd1;
          end
          fruit_eaten <= eat_q;
          update_done <= 1'b1;
        end
        DEAD: if (restart) score <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_update_sequencer.sv
// tb/tb_snake_update_sequencer.sv - self-checking bench: body RAM, snake queue model, vector table, random steps
module tb_snake_update_sequencer;
  localparam int LW   = 4;
  localparam int MAXL = 15;
  localparam int GW   = 80;
  localparam int GH   = 60;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          game_tik = 1'b0, restart = 1'b0;
  logic          up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [6:0]    fruit_x = '0, fruit_y = '0;
  logic [LW-1:0] body_addr;
  logic          body_we;
  logic [6:0]    body_wr_x, body_wr_y;
  logic [6:0]    body_rd_x = '0, body_rd_y = '0;
  logic [6:0]    snake_head_x, snake_head_y;
  logic [LW-1:0] snake_length;
  logic [7:0]    score;
  logic          busy, update_done, fruit_eaten, collision_detected;

  logic [6:0]    ram_x [16];
  logic [6:0]    ram_y [16];
  int            vectors = 0, miscompares = 0;
  int            we_cnt = 0, ud_cnt = 0;
  int            last_coll = 0;

  int            mx [16];
  int            my [16];
  int            mlen, mdir, mscore;

  typedef struct {
    bit u, d, l, r;
    int fx, fy, ex, ey, elen, escore;
    bit dead;
  } vec_t;
  vec_t tbl [8];

  always #20 clk = ~clk;

  snake_update_sequencer #(.SNAKE_LENGTH_BIT(LW), .GRID_W(GW), .GRID_H(GH)) dut (
    .clock_25(clk), .reset(rst_n), .game_tik(game_tik), .restart(restart),
    .up(up), .down(down), .left(left), .right(right),
    .fruit_x(fruit_x), .fruit_y(fruit_y),
    .body_addr(body_addr), .body_we(body_we), .body_wr_x(body_wr_x), .body_wr_y(body_wr_y),
    .body_rd_x(body_rd_x), .body_rd_y(body_rd_y),
    .snake_head_x(snake_head_x), .snake_head_y(snake_head_y),
    .snake_length(snake_length), .score(score), .busy(busy),
    .update_done(update_done), .fruit_eaten(fruit_eaten), .collision_detected(collision_detected)
  );

  always @(posedge clk) begin
    if (body_we) begin
      ram_x[body_addr] <= body_wr_x;
      ram_y[body_addr] <= body_wr_y;
    end
    body_rd_x <= ram_x[body_addr];
    body_rd_y <= ram_y[body_addr];
    if (body_we)     we_cnt <= we_cnt + 1;
    if (update_done) ud_cnt <= ud_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_init();
    mx[0] = GW / 2;     my[0] = GH / 2;
    mx[1] = GW / 2 - 1; my[1] = GH / 2;
    mlen = 2; mdir = 3; mscore = 0;
  endtask

  // Directions: 0 up, 1 down, 2 left, 3 right. kind: 0 moved, 1 wall, 2 self.
  task automatic model_step(input bit u, input bit d, input bit l, input bit r, input int fx, input int fy,
                            output int kind, output int edges, output int writes, output int ate);
    int cand, nx, ny, top, hit;
    bit off, eat, grow;
    cand = u ? 0 : d ? 1 : l ? 2 : r ? 3 : -1;
    if (cand >= 0 && cand != (mdir ^ 1)) mdir = cand;
    nx = mx[0] + ((mdir == 3) ? 1 : 0) - ((mdir == 2) ? 1 : 0);
    ny = my[0] + ((mdir == 1) ? 1 : 0) - ((mdir == 0) ? 1 : 0);
`ifdef SNAKE_WRAP_EN
    if (nx < 0) nx = GW - 1;
    if (nx >= GW) nx = 0;
    if (ny < 0) ny = GH - 1;
    if (ny >= GH) ny = 0;
    off = 1'b0;
`else
    off = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
`endif
    kind = 0; edges = 0; writes = 0; ate = 0;
    if (off) begin
      kind = 1; edges = 1;
    end else begin
      eat  = (nx == fx) && (ny == fy);
      grow = eat && (mlen < MAXL);
      top  = grow ? mlen : mlen - 1;
      hit  = -1;
      for (int j = top - 1; j >= 0; j--)
        if (hit < 0 && mx[j] == nx && my[j] == ny) hit = j;
      if (hit >= 0) begin
        kind = 2; edges = 3 + 2 * (top - 1 - hit); writes = top - 1 - hit;
      end else begin
        for (int j = top; j >= 1; j--) begin
          mx[j] = mx[j-1]; my[j] = my[j-1];
        end
        mx[0] = nx; my[0] = ny;
        if (grow) mlen++;
        if (eat && mscore < 255) mscore++;
        edges = 2 * top + 2; writes = top + 1; ate = eat ? 1 : 0;
      end
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".head_x"}, int'(snake_head_x), mx[0]);
    check({tag, ".head_y"}, int'(snake_head_y), my[0]);
    check({tag, ".length"}, int'(snake_length), mlen);
    check({tag, ".score"},  int'(score), mscore);
    for (int j = 0; j < mlen; j++) begin
      check($sformatf("%s.body%0d_x", tag, j), int'(ram_x[j]), mx[j]);
      check($sformatf("%s.body%0d_y", tag, j), int'(ram_y[j]), my[j]);
    end
  endtask

  task automatic do_step(input bit u, input bit d, input bit l, input bit r, input int fx, input int fy,
                         input bit extra, output int kind);
    int edges, writes, ate, n, we0, ud0;
    bit seen;
    model_step(u, d, l, r, fx, fy, kind, edges, writes, ate);
    @(negedge clk);
    up = u; down = d; left = l; right = r;
    fruit_x = 7'(fx); fruit_y = 7'(fy);
    game_tik = 1'b1;
    we0 = we_cnt; ud0 = ud_cnt;
    @(posedge clk); #1 game_tik = 1'b0;
    seen = 1'b0; n = 0;
    while (!seen && n < 60) begin
      @(posedge clk); #1 n++;
      if (extra) game_tik = (n == 2);
      if (update_done || collision_detected) seen = 1'b1;
    end
    game_tik = 1'b0; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    last_coll = int'(collision_detected);
    check("step.seen", int'(seen), 1);
    check("step.latency", n, edges);
    check("step.collision", int'(collision_detected), (kind != 0) ? 1 : 0);
    check("step.update_done", int'(update_done), (kind == 0) ? 1 : 0);
    check("step.busy", int'(busy), 0);
    check("step.writes", we_cnt - we0, writes);
    if (kind == 0) begin
      check("step.fruit_eaten", int'(fruit_eaten), ate);
      check_state("step");
    end
    if (extra) begin
      repeat (4) @(posedge clk);
      #1;
      check("step.tik_dropped", ud_cnt - ud0, 1);
      check("step.tik_dropped_busy", int'(busy), 0);
    end
  endtask

  task automatic do_restart(input bit with_tik);
    @(negedge clk);
    restart = 1'b1; game_tik = with_tik;
    @(posedge clk); #1 restart = 1'b0; game_tik = 1'b0;
    check("restart.busy0", int'(busy), 1);
    @(posedge clk); #1 check("restart.busy1", int'(busy), 1);
    @(posedge clk); #1 check("restart.busy2", int'(busy), 0);
    model_init();
    check_state("restart");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".busy"},      int'(busy), 1);
    check({tag, ".body_we"},   int'(body_we), 0);
    check({tag, ".head_x"},    int'(snake_head_x), GW / 2);
    check({tag, ".head_y"},    int'(snake_head_y), GH / 2);
    check({tag, ".length"},    int'(snake_length), 0);
    check({tag, ".score"},     int'(score), 0);
    check({tag, ".pulses"},    int'({update_done, fruit_eaten, collision_detected}), 0);
  endtask

  task automatic release_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 check("init.busy1", int'(busy), 1);
    @(posedge clk); #1 check("init.busy2", int'(busy), 0);
    model_init();
    check_state("init");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, ud0, sel, k, fx, fy;
    logic [3:0] m;

    tbl[0] = '{0, 0, 0, 0,  0,  0, 41, 30, 2, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 42, 30, 42, 30, 3, 1, 0};
    tbl[2] = '{0, 0, 1, 0,  0,  0, 43, 30, 3, 1, 0};
    tbl[3] = '{0, 1, 0, 0, 43, 31, 43, 31, 4, 2, 0};
    tbl[4] = '{0, 1, 0, 0, 43, 32, 43, 32, 5, 3, 0};
    tbl[5] = '{0, 0, 1, 0,  0,  0, 42, 32, 5, 3, 0};
    tbl[6] = '{1, 0, 0, 0,  0,  0, 42, 31, 5, 3, 0};
    tbl[7] = '{0, 0, 0, 1,  0,  0,  0,  0, 0, 0, 1};

    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    release_reset();

    for (int t = 0; t < 8; t++) begin
      do_step(tbl[t].u, tbl[t].d, tbl[t].l, tbl[t].r, tbl[t].fx, tbl[t].fy, 1'b0, kind);
      check($sformatf("tbl%0d.dead", t), last_coll, tbl[t].dead ? 1 : 0);
      if (!tbl[t].dead) begin
        check($sformatf("tbl%0d.head_x", t), int'(snake_head_x), tbl[t].ex);
        check($sformatf("tbl%0d.head_y", t), int'(snake_head_y), tbl[t].ey);
        check($sformatf("tbl%0d.length", t), int'(snake_length), tbl[t].elen);
        check($sformatf("tbl%0d.score", t),  int'(score), tbl[t].escore);
      end
    end

    // DEAD ignores game_tik
    ud0 = ud_cnt;
    @(negedge clk) game_tik = 1'b1;
    @(negedge clk) game_tik = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("dead.tik_ignored", ud_cnt - ud0, 0);
    check("dead.busy", int'(busy), 0);
    do_restart(1'b0);

    do_step(0, 0, 0, 0, 0, 0, 1'b1, kind);
    do_restart(1'b1);
    check("restart_wins.busy", int'(busy), 0);

    for (int s = 0; s < GW / 2 - 1; s++) do_step(0, 0, 0, 1, 0, 0, 1'b0, kind);
    check("wall.pre_x", int'(snake_head_x), GW - 1);
    do_step(0, 0, 0, 1, 0, 0, 1'b0, kind);
`ifdef SNAKE_WRAP_EN
    check("wall.wrap_x", int'(snake_head_x), 0);
    check("wall.wrap_coll", last_coll, 0);
`else
    check("wall.collision", last_coll, 1);
`endif
    do_restart(1'b0);

    for (int s = 0; s < 80; s++) begin
      sel = $urandom_range(0, 5);
      m = 4'b0000;
      if (sel < 4)       m[sel] = 1'b1;
      else if (sel == 5) m = 4'($urandom_range(0, 15));
      k  = $urandom_range(0, 3);
      fx = mx[0] + ((k == 3) ? 1 : 0) - ((k == 2) ? 1 : 0);
      fy = my[0] + ((k == 1) ? 1 : 0) - ((k == 0) ? 1 : 0);
      if ($urandom_range(0, 3) == 0 || fx < 0 || fx >= GW || fy < 0 || fy >= GH) begin
        fx = 0; fy = 0;
      end
      do_step(m[0], m[1], m[2], m[3], fx, fy, 1'b0, kind);
      if (kind != 0) do_restart(1'b0);
    end

    // Reset asserted mid-shift takes effect without a clock edge
    do_restart(1'b0);
    do_step(0, 0, 0, 0, GW / 2 + 1, GH / 2, 1'b0, kind);
    @(negedge clk) game_tik = 1'b1;
    @(posedge clk); #1 game_tik = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("midreset_hold");
    release_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
